// File: rtl/lsq_mem_arbiter_if.sv
// Bus bundle between the LSQ memory arbiter and its clients: load unit,
// store-queue head and the single-ported memory.
interface lsq_mem_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int LD_ID_W = 3
);
    logic               sq_valid;
    logic [XLEN-1:0]    sq_address;
    logic [XLEN-1:0]    sq_data;
    logic               sq_drain;
    logic               sq_retired;
    logic               ld_req_valid;
    logic [XLEN-1:0]    ld_req_addr;
    logic [LD_ID_W-1:0] ld_req_id;
    logic               ld_req_ready;
    logic               ld_resp_valid;
    logic [XLEN-1:0]    ld_resp_data;
    logic [LD_ID_W-1:0] ld_resp_id;
    logic [1:0]         proc2mem_command;
    logic [XLEN-1:0]    proc2mem_addr;
    logic [XLEN-1:0]    proc2mem_data;
    logic [TAG_W-1:0]   mem2proc_response;
    logic [TAG_W-1:0]   mem2proc_tag;
    logic [XLEN-1:0]    mem2proc_data;
    logic               arb_idle;

    modport master (
        input  sq_valid, sq_address, sq_data, sq_drain,
        input  ld_req_valid, ld_req_addr, ld_req_id,
        input  mem2proc_response, mem2proc_tag, mem2proc_data,
        output sq_retired, ld_req_ready,
        output ld_resp_valid, ld_resp_data, ld_resp_id,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output arb_idle
    );

    modport slave (
        output sq_valid, sq_address, sq_data, sq_drain,
        output ld_req_valid, ld_req_addr, ld_req_id,
        output mem2proc_response, mem2proc_tag, mem2proc_data,
        input  sq_retired, ld_req_ready,
        input  ld_resp_valid, ld_resp_data, ld_resp_id,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  arb_idle
    );
endinterface

// File: rtl/lsq_mem_arbiter.sv
// Single-port memory arbiter: picks a load or the committed head store each
// cycle, holds it on the bus until accepted, and matches load returns by tag.
module lsq_mem_arbiter #(
    parameter int XLEN            = 32,
    parameter int TAG_W           = 4,
    parameter int LD_ID_W         = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic               clock,
    input  logic               reset,
    lsq_mem_arbiter_if.master  bus
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int DEPTH = 1 << TAG_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [0:0]         state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [LD_ID_W-1:0] ld_id_q, ld_id_d;
    logic               tbl_valid_q [DEPTH];
    logic               tbl_valid_d [DEPTH];
    logic [LD_ID_W-1:0] tbl_id_q [DEPTH];
    logic [LD_ID_W-1:0] tbl_id_d [DEPTH];
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]    resp_data_q, resp_data_d;
    logic [LD_ID_W-1:0] resp_id_q, resp_id_d;

    logic accept, slot_free, ld_full, store_eligible, store_forced;
    logic ld_ready, cap_load, cap_store, alloc, complete;

    // A head store being accepted this cycle is already gone from the queue's
    // point of view, so it must not be captured a second time.
    assign accept         = (state_q == S_ISSUE) && (bus.mem2proc_response != '0);
    assign slot_free      = (state_q == S_IDLE) || accept;
    assign ld_full        = (outstanding_q == OUT_W'(MAX_OUTSTANDING));
    assign store_eligible = bus.sq_valid && !(accept && (cmd_q == CMD_STORE));
    assign store_forced   = store_eligible &&
                            (bus.sq_drain || (starve_q >= STV_W'(STARVE_LIMIT)));
    assign ld_ready       = slot_free && !ld_full && !store_forced;
    assign cap_load       = bus.ld_req_valid && ld_ready;
    assign cap_store      = !cap_load && slot_free && store_eligible;
    assign alloc          = accept && (cmd_q == CMD_LOAD);
    assign complete       = (bus.mem2proc_tag != '0) && tbl_valid_q[bus.mem2proc_tag];

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        data_d        = data_q;
        ld_id_d       = ld_id_q;
        tbl_valid_d   = tbl_valid_q;
        tbl_id_d      = tbl_id_q;
        starve_d      = starve_q;
        resp_valid_d  = complete;
        resp_data_d   = resp_data_q;
        resp_id_d     = resp_id_q;
        outstanding_d = outstanding_q + OUT_W'(alloc) - OUT_W'(complete);

        if (cap_load) begin
            state_d = S_ISSUE;
            cmd_d   = CMD_LOAD;
            addr_d  = bus.ld_req_addr;
            data_d  = '0;
            ld_id_d = bus.ld_req_id;
        end else if (cap_store) begin
            state_d = S_ISSUE;
            cmd_d   = CMD_STORE;
            addr_d  = bus.sq_address;
            data_d  = bus.sq_data;
            ld_id_d = '0;
        end else if (accept) begin
            state_d = S_IDLE;
            cmd_d   = CMD_NONE;
            addr_d  = '0;
            data_d  = '0;
            ld_id_d = '0;
        end

        // Allocation is applied after the clear so it wins a shared tag.
        if (complete) begin
            tbl_valid_d[bus.mem2proc_tag] = 1'b0;
            resp_data_d = bus.mem2proc_data;
            resp_id_d   = tbl_id_q[bus.mem2proc_tag];
        end
        if (alloc) begin
            tbl_valid_d[bus.mem2proc_response] = 1'b1;
            tbl_id_d[bus.mem2proc_response]    = ld_id_q;
        end

        if (!bus.sq_valid || cap_store) begin
            starve_d = '0;
        end else if (cap_load && store_eligible && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= CMD_NONE;
            addr_q        <= '0;
            data_q        <= '0;
            ld_id_q       <= '0;
            tbl_valid_q   <= '{default: 1'b0};
            tbl_id_q      <= '{default: '0};
            outstanding_q <= '0;
            starve_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            ld_id_q       <= ld_id_d;
            tbl_valid_q   <= tbl_valid_d;
            tbl_id_q      <= tbl_id_d;
            outstanding_q <= outstanding_d;
            starve_q      <= starve_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_id_q     <= resp_id_d;
        end
    end

    assign bus.sq_retired       = accept && (cmd_q == CMD_STORE);
    assign bus.ld_req_ready     = ld_ready;
    assign bus.ld_resp_valid    = resp_valid_q;
    assign bus.ld_resp_data     = resp_data_q;
    assign bus.ld_resp_id       = resp_id_q;
    assign bus.proc2mem_command = cmd_q;
    assign bus.proc2mem_addr    = addr_q;
    assign bus.proc2mem_data    = data_q;
    assign bus.arb_idle         = (state_q == S_IDLE) && (outstanding_q == '0) && !bus.sq_valid;
endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Self-checking bench for lsq_mem_arbiter: directed bus checks plus a
// scoreboard of expected load responses keyed to the cycle they must appear.
module tb_lsq_mem_arbiter;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 4;
    localparam int LD_ID_W = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lsq_mem_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W), .LD_ID_W(LD_ID_W)) bus();

    lsq_mem_arbiter #(
        .XLEN(XLEN), .TAG_W(TAG_W), .LD_ID_W(LD_ID_W),
        .MAX_OUTSTANDING(4), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [LD_ID_W-1:0] id;
        logic [XLEN-1:0]    data;
        int                 due;
    } resp_t;

    resp_t              sb[$];
    int                 checks   = 0;
    int                 failures = 0;
    int                 cyc      = 0;
    bit                 mon_en   = 1'b0;
    logic               model_valid [16];
    logic [LD_ID_W-1:0] model_id [16];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives every input for the coming edge; a completion of a tag the bench
    // knows to be outstanding queues the response expected one cycle later.
    task automatic applyStimulus(
        input logic ldv, input logic [XLEN-1:0] ldaddr, input logic [LD_ID_W-1:0] ldid,
        input logic sqv, input logic [XLEN-1:0] sqaddr, input logic [XLEN-1:0] sqdata,
        input logic drain, input logic [TAG_W-1:0] resp,
        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] tdata);
        resp_t e;
        bus.ld_req_valid      = ldv;
        bus.ld_req_addr       = ldaddr;
        bus.ld_req_id         = ldid;
        bus.sq_valid          = sqv;
        bus.sq_address        = sqaddr;
        bus.sq_data           = sqdata;
        bus.sq_drain          = drain;
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = tag;
        bus.mem2proc_data     = tdata;
        if (tag != '0 && model_valid[tag]) begin
            e.id   = model_id[tag];
            e.data = tdata;
            e.due  = cyc + 1;
            sb.push_back(e);
            model_valid[tag] = 1'b0;
        end
        #1;
    endtask

    task automatic allocate(input int tag, input logic [LD_ID_W-1:0] id);
        model_valid[tag] = 1'b1;
        model_id[tag]    = id;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // Response monitor: ld_resp_valid must be high exactly in the due cycle.
    always @(negedge clock) begin : monitor
        resp_t e;
        logic  exp_v;
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            checkOutput("resp_valid", bus.ld_resp_valid, exp_v);
            if (exp_v) begin
                e = sb.pop_front();
                if (bus.ld_resp_valid) begin
                    checkOutput("resp_id", bus.ld_resp_id, e.id);
                    checkOutput("resp_data", bus.ld_resp_data, e.data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            model_valid[i] = 1'b0;
            model_id[i]    = '0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_cmd", bus.proc2mem_command, 0);
        checkOutput("rst_addr", bus.proc2mem_addr, 0);
        checkOutput("rst_data", bus.proc2mem_data, 0);
        checkOutput("rst_resp_valid", bus.ld_resp_valid, 0);
        checkOutput("rst_resp_data", bus.ld_resp_data, 0);
        checkOutput("rst_retired", bus.sq_retired, 0);
        checkOutput("rst_ready", bus.ld_req_ready, 1);
        checkOutput("rst_idle", bus.arb_idle, 1);
        mon_en = 1'b1;

        $display("[TB] single load");
        applyStimulus(1, 32'h100, 5, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_ready", bus.ld_req_ready, 1);
        tick();
        checkOutput("t1_cmd", bus.proc2mem_command, 1);
        checkOutput("t1_addr", bus.proc2mem_addr, 32'h100);
        checkOutput("t1_data", bus.proc2mem_data, 0);
        checkOutput("t1_busy", bus.arb_idle, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        allocate(3, 5);
        checkOutput("t1_retired", bus.sq_retired, 0);
        tick();
        checkOutput("t1_cmd_done", bus.proc2mem_command, 0);
        checkOutput("t1_outstanding", bus.arb_idle, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'hDEAD);
        tick();
        idleCycle();
        checkOutput("t1_idle", bus.arb_idle, 1);

        $display("[TB] stalled store");
        applyStimulus(0, 0, 0, 1, 32'h200, 32'h55, 0, 0, 0, 0);
        checkOutput("t2_ready", bus.ld_req_ready, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 1, 32'h200, 32'h55, 0, 0, 0, 0);
            checkOutput("t2_cmd_hold", bus.proc2mem_command, 2);
            checkOutput("t2_addr_hold", bus.proc2mem_addr, 32'h200);
            checkOutput("t2_data_hold", bus.proc2mem_data, 32'h55);
            checkOutput("t2_retired_stall", bus.sq_retired, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 1, 32'h200, 32'h55, 0, 5, 0, 0);
        checkOutput("t2_cmd_acc", bus.proc2mem_command, 2);
        checkOutput("t2_addr_acc", bus.proc2mem_addr, 32'h200);
        checkOutput("t2_retired_acc", bus.sq_retired, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_no_dup", bus.proc2mem_command, 0);
        checkOutput("t2_retired_after", bus.sq_retired, 0);
        tick();

        $display("[TB] starvation of a waiting store");
        applyStimulus(1, 32'h1000, 0, 1, 32'h300, 32'h77, 0, 0, 0, 0);
        checkOutput("t3_ready0", bus.ld_req_ready, 1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            checkOutput("t3_cmd_load", bus.proc2mem_command, 1);
            checkOutput("t3_addr_load", bus.proc2mem_addr, 32'h1000 + 32'(4 * (i - 1)));
            applyStimulus(1, 32'h1000 + 32'(4 * i), LD_ID_W'(i), 1, 32'h300, 32'h77, 0,
                          TAG_W'(i), TAG_W'(i - 1), 32'hA000 + 32'(i));
            allocate(i, LD_ID_W'(i - 1));
            checkOutput("t3_ready", bus.ld_req_ready, 1);
            tick();
        end
        checkOutput("t3_cmd_load4", bus.proc2mem_command, 1);
        checkOutput("t3_addr_load4", bus.proc2mem_addr, 32'h100C);
        applyStimulus(1, 32'h1010, 4, 1, 32'h300, 32'h77, 0, 4, 3, 32'hA003);
        allocate(4, 3);
        checkOutput("t3_ready_starved", bus.ld_req_ready, 0);
        tick();
        checkOutput("t3_cmd_store", bus.proc2mem_command, 2);
        checkOutput("t3_addr_store", bus.proc2mem_addr, 32'h300);
        checkOutput("t3_data_store", bus.proc2mem_data, 32'h77);
        applyStimulus(1, 32'h1010, 4, 1, 32'h300, 32'h77, 0, 7, 4, 32'hA004);
        checkOutput("t3_retired", bus.sq_retired, 1);
        checkOutput("t3_ready_after", bus.ld_req_ready, 1);
        tick();
        checkOutput("t3_no_dup_store", bus.proc2mem_command, 1);
        checkOutput("t3_addr_next", bus.proc2mem_addr, 32'h1010);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        allocate(5, 4);
        tick();
        checkOutput("t3_cmd_none", bus.proc2mem_command, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hA005);
        tick();
        idleCycle();

        $display("[TB] outstanding limit");
        applyStimulus(1, 32'h2000, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h2004, 2, 0, 0, 0, 0, 1, 0, 0);
        allocate(1, 1);
        tick();
        applyStimulus(1, 32'h2008, 3, 0, 0, 0, 0, 2, 0, 0);
        allocate(2, 2);
        tick();
        applyStimulus(1, 32'h200C, 6, 0, 0, 0, 0, 3, 0, 0);
        allocate(3, 3);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
        allocate(4, 6);
        checkOutput("t4_ready_three", bus.ld_req_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_cmd_none", bus.proc2mem_command, 0);
        checkOutput("t4_ready_full", bus.ld_req_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2, 32'hBEEF);
        checkOutput("t4_ready_full_cmpl", bus.ld_req_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111);
        checkOutput("t4_ready_back", bus.ld_req_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h3333);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h4444);
        tick();
        idleCycle();
        checkOutput("t4_idle", bus.arb_idle, 1);

        $display("[TB] drain forces store");
        applyStimulus(1, 32'h3000, 7, 1, 32'h400, 32'h99, 1, 0, 0, 0);
        checkOutput("t5_ready_drain", bus.ld_req_ready, 0);
        tick();
        checkOutput("t5_cmd", bus.proc2mem_command, 2);
        checkOutput("t5_addr", bus.proc2mem_addr, 32'h400);
        applyStimulus(0, 0, 0, 1, 32'h400, 32'h99, 1, 9, 0, 0);
        checkOutput("t5_retired", bus.sq_retired, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_cmd_none", bus.proc2mem_command, 0);
        tick();

        $display("[TB] reset with load outstanding");
        applyStimulus(1, 32'h5000, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_cmd", bus.proc2mem_command, 1);
        applyStimulus(1, 32'h6000, 1, 0, 0, 0, 0, 6, 0, 0);
        allocate(6, 3);
        tick();
        checkOutput("t6_busy", bus.arb_idle, 0);
        checkOutput("t6_held", bus.proc2mem_command, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
        #1;
        checkOutput("t6_cmd_dropped", bus.proc2mem_command, 0);
        checkOutput("t6_idle_reset", bus.arb_idle, 1);
        checkOutput("t6_ready_reset", bus.ld_req_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 6, 6, 32'hBAD);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_no_resp", bus.ld_resp_valid, 0);
        checkOutput("t6_idle", bus.arb_idle, 1);
        checkOutput("t6_cmd_none", bus.proc2mem_command, 0);
        tick();
        tick();

        checkOutput("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
